// File: rtl/smolproc_pkg.sv
// smolproc_pkg: shared types and widths for the smolproc core
package smolproc_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_e;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int STREAK_W = 4;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and load/store, routes read responses
module mem_arbiter
  import smolproc_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W,
  parameter int MAX_DATA_STREAK = 3
) (
  input  logic          clk,
  input  logic          async_rst_n,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_rvalid,
  output logic [DW-1:0] fetch_rdata,
  input  logic          fetch_flush,
  input  logic          data_req,
  input  logic          data_we,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic          data_gnt,
  output logic          data_rvalid,
  output logic [DW-1:0] data_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  logic [STREAK_W-1:0] streak;
  owner_e owner, owner_nxt;
  logic data_win;
  always_comb begin
    data_win = data_req && (!fetch_req || streak < STREAK_W'(MAX_DATA_STREAK));
    data_gnt = async_rst_n && data_win;
    fetch_gnt = async_rst_n && fetch_req && !data_win;
    mem_en = data_gnt || fetch_gnt;
    mem_we = data_gnt && data_we;
    mem_addr = data_gnt ? data_addr : fetch_gnt ? fetch_addr : '0;
    mem_wdata = data_gnt ? data_wdata : '0;
    owner_nxt = (fetch_gnt && !fetch_flush) ? OWN_FETCH : (data_gnt && !data_we) ? OWN_DATA : OWN_NONE;
    fetch_rvalid = owner == OWN_FETCH && !fetch_flush;
    fetch_rdata = owner == OWN_FETCH ? mem_rdata : '0;
    data_rvalid = owner == OWN_DATA;
    data_rdata = owner == OWN_DATA ? mem_rdata : '0;
  end
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      owner <= OWN_NONE;
      streak <= '0;
    end else begin
      owner <= owner_nxt;
      if (!fetch_req || fetch_gnt) streak <= '0;
      else if (data_gnt && streak != '1) streak <= streak + 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, streak limit, response routing and flush
module tb_mem_arbiter;
  logic clk = 0, async_rst_n = 0;
  logic fetch_req = 0, fetch_flush = 0, data_req = 0, data_we = 0;
  logic [7:0] fetch_addr = 0, data_addr = 0, data_wdata = 0;
  logic fetch_gnt, fetch_rvalid, data_gnt, data_rvalid, mem_en, mem_we;
  logic [7:0] fetch_rdata, data_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [7:0] mem [256];
  logic load = 0;
  logic [7:0] load_addr = 0, load_data = 0;
  int checks = 0, errors = 0;

  mem_arbiter #(.AW(8), .DW(8), .MAX_DATA_STREAK(3)) dut (
    .clk(clk), .async_rst_n(async_rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_flush(fetch_flush),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous memory model: read data appears the cycle after the access
  always @(posedge clk) begin
    if (load) mem[load_addr] <= load_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    load = 1; load_addr = a; load_data = d;
    step();
    load = 0;
  endtask

  task automatic idle();
    fetch_req = 0; data_req = 0; data_we = 0; fetch_flush = 0;
  endtask

  initial begin
    preload(8'h10, 8'hA5);
    preload(8'h20, 8'h11);
    preload(8'h30, 8'h77);
    preload(8'h05, 8'h55);
    preload(8'h06, 8'h66);
    fetch_req = 1; data_req = 1; fetch_addr = 8'h10;
    #1;
    check("rst_fetch_gnt", fetch_gnt, 0);
    check("rst_data_gnt", data_gnt, 0);
    check("rst_mem_en", mem_en, 0);
    idle();
    @(negedge clk);
    async_rst_n = 1;
    step();
    check("post_rst_mem_en", mem_en, 0);
    check("post_rst_rvalid", {fetch_rvalid, data_rvalid}, 0);
    check("post_rst_addr", mem_addr, 0);

    // Fetch only
    fetch_req = 1; fetch_addr = 8'h10;
    #1;
    check("f_gnt", fetch_gnt, 1);
    check("f_mem_addr", mem_addr, 8'h10);
    check("f_mem_en_we", {mem_en, mem_we}, 2'b10);
    step();
    idle();
    #1;
    check("f_rvalid", fetch_rvalid, 1);
    check("f_rdata", fetch_rdata, 8'hA5);
    check("f_data_rvalid", data_rvalid, 0);

    // Data write under contention
    step();
    fetch_req = 1; fetch_addr = 8'h10;
    data_req = 1; data_we = 1; data_addr = 8'h40; data_wdata = 8'h3C;
    #1;
    check("w_data_gnt", data_gnt, 1);
    check("w_fetch_gnt", fetch_gnt, 0);
    check("w_mem_we", mem_we, 1);
    check("w_mem_addr", mem_addr, 8'h40);
    check("w_mem_wdata", mem_wdata, 8'h3C);
    step();
    idle();
    #1;
    check("w_no_rvalid", {fetch_rvalid, data_rvalid}, 0);
    step();

    // Starvation bound: D,D,D,F repeating
    fetch_req = 1; fetch_addr = 8'h30;
    data_req = 1; data_we = 0; data_addr = 8'h05;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("s_data_gnt", data_gnt, (i % 4) != 3);
      check("s_fetch_gnt", fetch_gnt, (i % 4) == 3);
      check("s_streak", dut.streak, i % 4);
      if (i > 0 && i % 4 == 0) begin
        check("s_f_rvalid", fetch_rvalid, 1);
        check("s_f_rdata", fetch_rdata, 8'h77);
      end else if (i > 0) begin
        check("s_d_rvalid", data_rvalid, 1);
        check("s_d_rdata", data_rdata, 8'h55);
      end
      step();
    end
    idle();
    step();

    // Flush in response cycle; data read alongside still returns
    fetch_req = 1; fetch_addr = 8'h20;
    #1;
    check("fl_gnt", fetch_gnt, 1);
    step();
    fetch_req = 0; fetch_flush = 1;
    data_req = 1; data_we = 0; data_addr = 8'h05;
    #1;
    check("fl_rvalid_killed", fetch_rvalid, 0);
    check("fl_data_gnt", data_gnt, 1);
    step();
    idle();
    #1;
    check("fl_data_rvalid", data_rvalid, 1);
    check("fl_data_rdata", data_rdata, 8'h55);
    check("fl_fetch_rvalid", fetch_rvalid, 0);

    // Flush in the grant cycle still grants but squashes the response
    step();
    fetch_req = 1; fetch_addr = 8'h20; fetch_flush = 1;
    #1;
    check("flg_gnt", fetch_gnt, 1);
    step();
    idle();
    #1;
    check("flg_rvalid", fetch_rvalid, 0);

    // Back-to-back: data read then fetch read
    step();
    data_req = 1; data_we = 0; data_addr = 8'h05;
    step();
    data_req = 0; fetch_req = 1; fetch_addr = 8'h06;
    #1;
    check("bb_data_rvalid", data_rvalid, 1);
    check("bb_data_rdata", data_rdata, 8'h55);
    check("bb_fetch_gnt", fetch_gnt, 1);
    check("bb_fetch_rvalid0", fetch_rvalid, 0);
    step();
    idle();
    #1;
    check("bb_fetch_rvalid", fetch_rvalid, 1);
    check("bb_fetch_rdata", fetch_rdata, 8'h66);
    check("bb_data_rvalid1", data_rvalid, 0);

    // Stored write readback
    step();
    data_req = 1; data_we = 0; data_addr = 8'h40;
    step();
    idle();
    #1;
    check("wr_readback", data_rdata, 8'h3C);

    // Async reset mid-cycle with a fetch response outstanding
    step();
    fetch_req = 1; fetch_addr = 8'h10;
    step();
    fetch_req = 1; data_req = 1; data_we = 0; data_addr = 8'h05;
    #1;
    check("ar_pre_rvalid", fetch_rvalid, 1);
    #1;
    async_rst_n = 0;
    #1;
    check("ar_rvalid", {fetch_rvalid, data_rvalid}, 0);
    check("ar_gnt", {fetch_gnt, data_gnt, mem_en}, 0);
    check("ar_rdata", {fetch_rdata, data_rdata}, 0);
    @(negedge clk);
    async_rst_n = 1;
    #1;
    check("ar_streak_clr", dut.streak, 0);
    for (int i = 0; i < 4; i++) begin
      check("ar_data_gnt", data_gnt, i != 3);
      if (i == 0) check("ar_no_stale", {fetch_rvalid, data_rvalid}, 0);
      step();
    end
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, expected end of stimulus");
    $fatal(1);
  end
endmodule
